ps2_mouse_sequencer: RTL
========================

# ps2_mouse_sequencer

Controller that brings up a PS/2 mouse and then runs it in stream mode. It sits between the debounced user buttons and the byte-level PS/2 transceiver. It sequences the init commands (reset, then enable data reporting) and checks every response byte. It then assembles the 3-byte movement packets into registered status/X/Y outputs with a valid strobe, which feed the LED/debug logic of the top level.

## Interface

Parameters:
- TIMEOUT_CYCLES, 25_000_000: maximum wait for any init response byte or tx completion (0.5 s at 50 MHz); must be < 2^26.
- GAP_CYCLES, 1_000_000: maximum gap between bytes of one stream packet (20 ms).
- MAX_RETRY, 3: init attempts before entering ERROR.

Ports:
- qzt_clk  in  1  50 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- restart  in  1  one-cycle pulse (debounced button); restarts init from any state.
- tx_busy  in  1  transceiver is sending; tx_start ignored while high.
- tx_done  in  1  one-cycle pulse, byte sent and device-ACK bit seen.
- tx_err  in  1  one-cycle pulse, transmit failed.
- rx_byte  in  8  received byte, valid with rx_valid.
- rx_valid  in  1  one-cycle pulse, new byte on rx_byte.
- tx_byte  out  8  command byte, held stable from tx_start until tx_done/tx_err.
- tx_start  out  1  one-cycle request to send tx_byte.
- status_pck_1  out  8  packet byte 1 (buttons, signs, overflow).
- xm_pck_2  out  8  packet byte 2, X movement.
- ym_pck_3  out  8  packet byte 3, Y movement.
- pck_valid  out  1  one-cycle pulse, new packet on the three outputs.
- init_done  out  1  high while in stream states.
- error  out  1  high in ERROR.
- state_dbg  out  4  current state encoding.

## Operation

- States and encodings: SEND_RST=0, WAIT_ACK1=1, WAIT_BAT=2, WAIT_ID=3, SEND_EN=4, WAIT_ACK2=5, STR_B1=6, STR_B2=7, STR_B3=8, ERROR=9.
- SEND_RST: tx_byte=0xFF. Pulse tx_start once tx_busy is low. Wait for tx_done, then go to WAIT_ACK1.
- WAIT_ACK1 expects 0xFA. WAIT_BAT expects 0xAA. WAIT_ID expects 0x00. Each matching byte advances to the next state.
- SEND_EN: tx_byte=0xF4, same handshake as SEND_RST, then WAIT_ACK2 (expects 0xFA), then STR_B1.
- Init failure is any of: wrong byte, tx_err, or timeout counter reaching TIMEOUT_CYCLES in any SEND/WAIT state. On failure, retry_cnt++. If retry_cnt < MAX_RETRY, go to SEND_RST; otherwise go to ERROR.
- retry_cnt clears on entering STR_B1.
- STR_B1: accept a byte only if bit3=1, store it to a shadow register, go to STR_B2. A byte with bit3=0 is discarded and the state stays STR_B1 (resync).
- STR_B2: store the X byte, go to STR_B3.
- STR_B3: copy the shadow bytes to status_pck_1/xm_pck_2/ym_pck_3, pulse pck_valid, go to STR_B1.
- In STR_B2/STR_B3 the gap counter restarts on every rx_valid. If it reaches GAP_CYCLES, the partial packet is dropped and the state goes to STR_B1. Outputs are not modified.
- There is no timeout in STR_B1.
- ERROR holds until restart.
- restart in any state: retry_cnt=0, counters cleared, go to SEND_RST. Packet outputs keep their values.
- restart has priority over rx_valid/tx_done/timeouts arriving in the same cycle.
- rx_valid during a SEND state is ignored.

## Timing

- Reset values: state=SEND_RST, tx_byte=0x00, tx_start=0, packet outputs=0x00, pck_valid=0, init_done=0, error=0, state_dbg=0, retry_cnt=0, counters=0.
- First tx_start occurs on the first clock edge after reset deasserts with tx_busy low. tx_byte=0xFF is registered in the same cycle.
- tx_start is high for exactly one cycle per command. It is never reasserted before tx_done/tx_err.
- State changes occur on the edge that samples rx_valid/tx_done. pck_valid is high in the cycle after the edge sampling the third byte, with the data already updated.
- The timeout counter resets on every state entry. A timeout fires on the edge where the count equals TIMEOUT_CYCLES-1.
- init_done and error are registered decodes of the state and follow it by 0 cycles (same register).

## Test plan

- Clean init: after reset, expect 0xFF sent. Reply FA, AA, 00. Expect 0xF4 sent. Reply FA. Then init_done=1, state_dbg=6, retry_cnt=0.
- Stream packet: in STR_B1, feed 0x09, 0x05, 0xFB. Expect a pck_valid pulse with status=0x09, x=0x05, y=0xFB. Then feed 0x01 (bit3=0): discarded, state stays 6.
- Retry/error (MAX_RETRY=3, TIMEOUT_CYCLES=100): reply 0xFE to every 0xFF. Expect 3 reset commands, then error=1, state_dbg=9, no further tx_start. A restart pulse then gives 0xFF resent and error=0.
- Inter-byte timeout (GAP_CYCLES=50): feed 0x08, wait 60 cycles, feed 0x18, 0x01, 0x02. Expect a single packet 0x18/0x01/0x02 and no packet containing 0x08.
- tx_err during SEND_EN: expect retry back to SEND_RST with retry_cnt=1 and tx_byte=0xFF on the next tx_start.
- Reset mid-packet: assert reset after byte 2 of a packet. Expect all outputs at their reset values, state_dbg=0, and no pck_valid.

Source files
------------

// File: rtl/ps2_mouse_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_mouse_sequencer
//
// Brings up a PS/2 mouse and then runs it in stream mode. The init sequence
// sends 0xFF (reset) and expects 0xFA, 0xAA, 0x00. It then sends 0xF4
// (enable data reporting) and expects 0xFA. Any wrong byte, transmit error
// or timeout triggers a retry, up to MAX_RETRY attempts in total, after which
// the block parks in ERROR until restart. In stream mode, 3-byte movement
// packets are assembled and published on registered outputs with a
// one-cycle valid strobe.
//
// Ports
//   qzt_clk       system clock, rising edge
//   reset         asynchronous, active-high reset
//   restart       one-cycle pulse, restarts init from any state
//   tx_busy       transceiver busy; a command is only issued while low
//   tx_done       one-cycle pulse, command byte sent and acknowledged
//   tx_err        one-cycle pulse, command transmit failed
//   rx_byte       received byte, qualified by rx_valid
//   rx_valid      one-cycle pulse, new byte on rx_byte
//   tx_byte       command byte, stable from tx_start until tx_done/tx_err
//   tx_start      one-cycle request to send tx_byte
//   status_pck_1  packet byte 1 (buttons, signs, overflow)
//   xm_pck_2      packet byte 2, X movement
//   ym_pck_3      packet byte 3, Y movement
//   pck_valid     one-cycle pulse, new packet on the three packet outputs
//   init_done     high while in the stream states
//   error         high in ERROR
//   state_dbg     current state encoding
// ---------------------------------------------------------------------------
module ps2_mouse_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES     = 1_000_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       qzt_clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       tx_busy,
   input  logic       tx_done,
   input  logic       tx_err,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [7:0] tx_byte,
   output logic       tx_start,
   output logic [7:0] status_pck_1,
   output logic [7:0] xm_pck_2,
   output logic [7:0] ym_pck_3,
   output logic       pck_valid,
   output logic       init_done,
   output logic       error,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      SEND_RST  = 4'd0,
      WAIT_ACK1 = 4'd1,
      WAIT_BAT  = 4'd2,
      WAIT_ID   = 4'd3,
      SEND_EN   = 4'd4,
      WAIT_ACK2 = 4'd5,
      STR_B1    = 4'd6,
      STR_B2    = 4'd7,
      STR_B3    = 4'd8,
      ERROR     = 4'd9
   } state_t;

   localparam int unsigned RW           = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);
   localparam logic [25:0] GAP_LAST     = 26'(GAP_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

   state_t          state_q, state_d;
   logic [25:0]     cnt_q;          // shared init-timeout / packet-gap counter
   logic            sent_q;         // command already issued in this SEND state
   logic [RW-1:0]   retry_cnt, retry_d;
   logic [7:0]      shadow_status, shadow_x;

   logic            fail, load_tx, cnt_en, reenter;
   logic            take_b1, take_b2, take_b3;
   logic [7:0]      tx_cmd, exp_byte;

   // NOTE: every signal written below gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      retry_d  = retry_cnt;
      fail     = 1'b0;
      load_tx  = 1'b0;
      cnt_en   = 1'b0;
      tx_cmd   = 8'hFF;
      exp_byte = 8'h00;
      take_b1  = 1'b0;
      take_b2  = 1'b0;
      take_b3  = 1'b0;

      case (state_q)
         SEND_RST, SEND_EN: begin
            cnt_en = 1'b1;
            tx_cmd = (state_q == SEND_EN) ? 8'hF4 : 8'hFF;
            if (!sent_q)      load_tx = !tx_busy;
            else if (tx_err)  fail    = 1'b1;
            else if (tx_done) state_d = (state_q == SEND_EN) ? WAIT_ACK2 : WAIT_ACK1;
            if (cnt_q == TIMEOUT_LAST && state_d == state_q) fail = 1'b1;
         end
         WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
            cnt_en   = 1'b1;
            exp_byte = (state_q == WAIT_BAT) ? 8'hAA :
                       (state_q == WAIT_ID)  ? 8'h00 : 8'hFA;
            // The encodings are ordered so each matched response steps to
            // the next state (WAIT_ID -> SEND_EN, WAIT_ACK2 -> STR_B1).
            if (rx_valid) begin
               if (rx_byte == exp_byte) state_d = state_t'(state_q + 4'd1);
               else                     fail    = 1'b1;
            end else if (cnt_q == TIMEOUT_LAST) begin
               fail = 1'b1;
            end
         end
         STR_B1: begin
            // Only a byte with bit 3 set can start a packet (resync).
            if (rx_valid && rx_byte[3]) begin
               take_b1 = 1'b1;
               state_d = STR_B2;
            end
         end
         STR_B2, STR_B3: begin
            cnt_en = 1'b1;
            if (rx_valid) begin
               take_b2 = (state_q == STR_B2);
               take_b3 = (state_q == STR_B3);
               state_d = (state_q == STR_B2) ? STR_B3 : STR_B1;
            end else if (cnt_q == GAP_LAST) begin
               state_d = STR_B1;
            end
         end
         ERROR:   ;
         default: state_d = SEND_RST;
      endcase

      if (fail) begin
         load_tx = 1'b0;
         retry_d = retry_cnt + RW'(1);
         state_d = (retry_cnt < RETRY_LAST) ? SEND_RST : ERROR;
      end

      if (state_q == WAIT_ACK2 && state_d == STR_B1) retry_d = '0;

      if (restart) begin
         state_d = SEND_RST;
         retry_d = '0;
         fail    = 1'b0;
         load_tx = 1'b0;
         take_b1 = 1'b0;
         take_b2 = 1'b0;
         take_b3 = 1'b0;
      end

      // A retry into SEND_RST from SEND_RST is still a fresh entry.
      reenter = restart || fail || (state_d != state_q);
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         state_q   <= SEND_RST;
         init_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_done <= (state_d == STR_B1) || (state_d == STR_B2) || (state_d == STR_B3);
         error     <= (state_d == ERROR);
      end
   end

   assign state_dbg = state_q;

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         sent_q        <= 1'b0;
         retry_cnt     <= '0;
         tx_byte       <= 8'h00;
         tx_start      <= 1'b0;
         shadow_status <= 8'h00;
         shadow_x      <= 8'h00;
         status_pck_1  <= 8'h00;
         xm_pck_2      <= 8'h00;
         ym_pck_3      <= 8'h00;
         pck_valid     <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         pck_valid <= 1'b0;
         retry_cnt <= retry_d;

         if (reenter) begin
            cnt_q  <= '0;
            sent_q <= 1'b0;
         end else if (cnt_en) begin
            cnt_q  <= cnt_q + 26'd1;
         end

         if (load_tx) begin
            tx_start <= 1'b1;
            tx_byte  <= tx_cmd;
            sent_q   <= 1'b1;
         end

         if (take_b1) shadow_status <= rx_byte;
         if (take_b2) shadow_x      <= rx_byte;
         if (take_b3) begin
            status_pck_1 <= shadow_status;
            xm_pck_2     <= shadow_x;
            ym_pck_3     <= rx_byte;
            pck_valid    <= 1'b1;
         end
      end
   end

endmodule
